// File: rtl/switch_port_sink.sv
// Egress sink for one switch output port: destination check, FIFO buffering, registered valid/ready output.
// Optional SWITCH_SINK_ORDER_CHECK_EN adds payload sequence checking (seq_err_count).
module switch_port_sink #(
  parameter int PORT_ID        = 0,
  parameter int DEPTH          = 8,
  parameter int SUSPEND_MARGIN = 2,
  parameter int CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_op,
  input  logic [15:0]              data_op,
  output logic                     suspend_op,
  output logic                     out_valid,
  output logic [15:0]              out_data,
  input  logic                     out_ready,
  input  logic                     stats_clr,
  output logic [CNT_W-1:0]         pkt_count,
  output logic [CNT_W-1:0]         misroute_count,
  output logic [CNT_W-1:0]         overflow_count,
`ifdef SWITCH_SINK_ORDER_CHECK_EN
  output logic [CNT_W-1:0]         seq_err_count,
`endif
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_LVL = OW'(DEPTH);
  localparam logic [OW-1:0] SUSP_LVL = OW'(DEPTH - SUSPEND_MARGIN);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic [15:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             state_q, state_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             suspend_q, suspend_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic fifo_empty, fifo_full, dest_hit;
  logic push, pop, misroute, overflow;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    fifo_empty = (occ_q == '0);
    fifo_full  = (occ_q == FULL_LVL);
    dest_hit   = data_op[PORT_ID];
    // EMPTY refills unconditionally; FULL refills only as the consumer takes the current word.
    pop        = !fifo_empty && ((state_q == ST_EMPTY) || out_ready);
    misroute   = valid_op && !dest_hit;
    push       = valid_op && dest_hit && (!fifo_full || pop);
    overflow   = valid_op && dest_hit && fifo_full && !pop;

    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    occ_d      = occ_q + OW'(push) - OW'(pop);
    suspend_d  = (occ_d >= SUSP_LVL);

    state_d    = state_q;
    out_data_d = out_data_q;
    if (pop) begin
      state_d    = ST_FULL;
      out_data_d = mem_q[rd_ptr_q];
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d    = ST_EMPTY;
    end

    pkt_cnt_d = stats_clr ? '0 : sat_inc(pkt_cnt_q, push);
    mis_cnt_d = stats_clr ? '0 : sat_inc(mis_cnt_q, misroute);
    ovf_cnt_d = stats_clr ? '0 : sat_inc(ovf_cnt_q, overflow);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_op;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      suspend_q  <= 1'b0;
      pkt_cnt_q  <= '0;
      mis_cnt_q  <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      state_q    <= state_d;
      out_data_q <= out_data_d;
      suspend_q  <= suspend_d;
      pkt_cnt_q  <= pkt_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

`ifdef SWITCH_SINK_ORDER_CHECK_EN
  logic [11:0]      seq_exp_q, seq_exp_d;
  logic             seq_first_q, seq_first_d;
  logic [CNT_W-1:0] seq_err_q, seq_err_d;
  logic [11:0]      payload;

  // The first accepted packet after reset/clear only seeds the expected sequence.
  always_comb begin
    payload     = data_op[15:4];
    seq_exp_d   = seq_exp_q;
    seq_first_d = seq_first_q;
    seq_err_d   = seq_err_q;
    if (stats_clr) begin
      seq_first_d = 1'b1;
      seq_err_d   = '0;
    end else if (push) begin
      seq_first_d = 1'b0;
      if (seq_first_q || (payload != seq_exp_q)) begin
        seq_exp_d = payload + 12'd1;
        if (!seq_first_q) seq_err_d = sat_inc(seq_err_q, 1'b1);
      end else begin
        seq_exp_d = seq_exp_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_exp_q   <= '0;
      seq_first_q <= 1'b1;
      seq_err_q   <= '0;
    end else begin
      seq_exp_q   <= seq_exp_d;
      seq_first_q <= seq_first_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign seq_err_count = seq_err_q;
`endif

  assign suspend_op     = suspend_q;
  assign out_valid      = (state_q == ST_FULL);
  assign out_data       = out_data_q;
  assign pkt_count      = pkt_cnt_q;
  assign misroute_count = mis_cnt_q;
  assign overflow_count = ovf_cnt_q;
  assign occupancy      = occ_q;

endmodule
